alu_exec_sequencer: RTL and testbench

- Execute-stage controller that sequences the shared combinational ALU for decoded R-type operations.
- Single-cycle ops (AND/OR/ADD/SUB/SLL/SRL/XOR) make one pass through the ALU.
- MUL (code 4'b0110) is run as an iterative shift-and-add multiply that reuses the ALU adder, one step per cycle.
- Sits between the control/decode unit and register-file write-back, with valid/ready handshakes on both sides.

---
 rtl/alu_exec_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_alu_exec_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_sequencer.sv
// Execute-stage sequencer for the shared combinational ALU: single-pass R-type ops and an iterative
// shift-and-add MUL that reuses the ALU adder. Define MUL_EARLY_EXIT_EN to stop MUL once the multiplier is exhausted.
module alu_exec_sequencer #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_alu_control,
    input  logic [XLEN-1:0] in_op_a,
    input  logic [XLEN-1:0] in_op_b,
    input  logic [RD_W-1:0] in_rd,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_ctl,
    input  logic [XLEN-1:0] alu_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [RD_W-1:0] out_rd,
    output logic [XLEN-1:0] out_data,
    output logic            out_regwrite,
    output logic            out_illegal,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [3:0] CTL_ADD = 4'b0010;
    localparam logic [3:0] CTL_MUL = 4'b0110;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_ITER = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t            state_r, state_s;
    logic [XLEN-1:0]   op_a_r, op_a_s;
    logic [XLEN-1:0]   op_b_r, op_b_s;
    logic [RD_W-1:0]   rd_r, rd_s;
    logic [3:0]        ctl_r, ctl_s;
    logic [XLEN-1:0]   acc_r, acc_s;
    logic [XLEN-1:0]   mcand_r, mcand_s;
    logic [XLEN-1:0]   mplier_r, mplier_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [XLEN-1:0]   out_data_r, out_data_s;
    logic [RD_W-1:0]   out_rd_r, out_rd_s;
    logic              out_regwrite_r, out_regwrite_s;
    logic              out_illegal_r, out_illegal_s;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              busy_r;
    logic [XLEN-1:0]   alu_a_s, alu_b_s;
    logic [3:0]        alu_ctl_s;
    logic              mul_last_s;
    logic [XLEN-1:0]   mplier_shr_s;

    // Next-state, datapath updates and ALU operand steering for the current state
    always_comb begin
        state_s        = state_r;
        op_a_s         = op_a_r;
        op_b_s         = op_b_r;
        rd_s           = rd_r;
        ctl_s          = ctl_r;
        acc_s          = acc_r;
        mcand_s        = mcand_r;
        mplier_s       = mplier_r;
        cnt_s          = cnt_r;
        out_data_s     = out_data_r;
        out_rd_s       = out_rd_r;
        out_regwrite_s = out_regwrite_r;
        out_illegal_s  = out_illegal_r;
        alu_a_s        = {XLEN{1'b0}};
        alu_b_s        = {XLEN{1'b0}};
        alu_ctl_s      = CTL_ADD;
        mplier_shr_s   = {1'b0, mplier_r[XLEN-1:1]};
`ifdef MUL_EARLY_EXIT_EN
        mul_last_s     = (cnt_r == CNT_LAST) || (mplier_shr_s == {XLEN{1'b0}});
`else
        mul_last_s     = (cnt_r == CNT_LAST);
`endif

        case (state_r)
            ST_IDLE: begin
                if (in_valid) begin
                    op_a_s = in_op_a;
                    op_b_s = in_op_b;
                    rd_s   = in_rd;
                    ctl_s  = in_alu_control;
                    if (in_alu_control == CTL_MUL) begin
                        acc_s    = {XLEN{1'b0}};
                        mcand_s  = in_op_a;
                        mplier_s = in_op_b;
                        cnt_s    = {CNT_W{1'b0}};
                        state_s  = ST_MUL_ITER;
                    end else begin
                        state_s  = ST_EXEC;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                alu_a_s  = op_a_r;
                alu_b_s  = op_b_r;
                out_rd_s = rd_r;
                // Codes 1xxx have no ALU meaning: keep the ALU on a harmless ADD and suppress the write
                if (ctl_r[3]) begin
                    alu_ctl_s      = CTL_ADD;
                    out_data_s     = {XLEN{1'b0}};
                    out_regwrite_s = 1'b0;
                    out_illegal_s  = 1'b1;
                end else begin
                    alu_ctl_s      = ctl_r;
                    out_data_s     = alu_result;
                    out_regwrite_s = 1'b1;
                    out_illegal_s  = 1'b0;
                end
                state_s = ST_DONE;
            end
            ST_MUL_ITER: begin
                alu_a_s   = acc_r;
                alu_b_s   = mcand_r;
                alu_ctl_s = CTL_ADD;
                if (mplier_r[0]) begin
                    acc_s = alu_result;
                end else begin
                    acc_s = acc_r;
                end
                mcand_s  = {mcand_r[XLEN-2:0], 1'b0};
                mplier_s = mplier_shr_s;
                cnt_s    = cnt_r + CNT_W'(1);
                if (mul_last_s) begin
                    out_data_s     = acc_s;
                    out_rd_s       = rd_r;
                    out_regwrite_s = 1'b1;
                    out_illegal_s  = 1'b0;
                    state_s        = ST_DONE;
                end else begin
                    state_s = ST_MUL_ITER;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; handshake flags are registered from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            op_a_r         <= {XLEN{1'b0}};
            op_b_r         <= {XLEN{1'b0}};
            rd_r           <= {RD_W{1'b0}};
            ctl_r          <= 4'b0000;
            acc_r          <= {XLEN{1'b0}};
            mcand_r        <= {XLEN{1'b0}};
            mplier_r       <= {XLEN{1'b0}};
            cnt_r          <= {CNT_W{1'b0}};
            out_data_r     <= {XLEN{1'b0}};
            out_rd_r       <= {RD_W{1'b0}};
            out_regwrite_r <= 1'b0;
            out_illegal_r  <= 1'b0;
            out_valid_r    <= 1'b0;
            in_ready_r     <= 1'b1;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            op_a_r         <= op_a_s;
            op_b_r         <= op_b_s;
            rd_r           <= rd_s;
            ctl_r          <= ctl_s;
            acc_r          <= acc_s;
            mcand_r        <= mcand_s;
            mplier_r       <= mplier_s;
            cnt_r          <= cnt_s;
            out_data_r     <= out_data_s;
            out_rd_r       <= out_rd_s;
            out_regwrite_r <= out_regwrite_s;
            out_illegal_r  <= out_illegal_s;
            out_valid_r    <= (state_s == ST_DONE);
            in_ready_r     <= (state_s == ST_IDLE);
            busy_r         <= (state_s != ST_IDLE);
        end
    end

    assign in_ready     = in_ready_r;
    assign busy         = busy_r;
    assign out_valid    = out_valid_r;
    assign out_data     = out_data_r;
    assign out_rd       = out_rd_r;
    assign out_regwrite = out_regwrite_r;
    assign out_illegal  = out_illegal_r;
    assign alu_a        = alu_a_s;
    assign alu_b        = alu_b_s;
    assign alu_ctl      = alu_ctl_s;

endmodule

// File: tb/tb_alu_exec_sequencer.sv
// Self-checking bench for alu_exec_sequencer: directed vector table, backpressure and reset corner cases,
// then random ops checked against a behavioural model. Honours MUL_EARLY_EXIT_EN like the design.
module tb_alu_exec_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_alu_control;
    logic [31:0] in_op_a, in_op_b;
    logic [4:0]  in_rd;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [3:0]  alu_ctl;
    logic        out_valid, out_ready;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_regwrite, out_illegal, busy;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        regwrite;
        logic        illegal;
        int          lat;
    } vec_t;

    alu_exec_sequencer #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_control(in_alu_control),
        .in_op_a(in_op_a), .in_op_b(in_op_b), .in_rd(in_rd),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctl(alu_ctl), .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd), .out_data(out_data),
        .out_regwrite(out_regwrite), .out_illegal(out_illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // The shared combinational ALU that sits outside the sequencer
    always_comb begin
        case (alu_ctl)
            4'b0000: alu_result = alu_a & alu_b;
            4'b0001: alu_result = alu_a | alu_b;
            4'b0010: alu_result = alu_a + alu_b;
            4'b0011: alu_result = alu_a << alu_b[4:0];
            4'b0100: alu_result = alu_a - alu_b;
            4'b0101: alu_result = alu_a >> alu_b[4:0];
            4'b0111: alu_result = alu_a ^ alu_b;
            default: alu_result = 32'd0;
        endcase
    end

    function automatic logic [31:0] ref_data(logic [3:0] c, logic [31:0] a, logic [31:0] b);
        case (c)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a + b;
            4'b0011: return a << b[4:0];
            4'b0100: return a - b;
            4'b0101: return a >> b[4:0];
            4'b0110: return a * b;
            4'b0111: return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int ref_lat(logic [3:0] c, logic [31:0] b);
        int iters;
        if (c != 4'b0110) return 2;
`ifdef MUL_EARLY_EXIT_EN
        iters = 1;
        for (int i = 0; i < 32; i++) if (b[i]) iters = i + 1;
`else
        iters = 32;
`endif
        return iters + 1;
    endfunction

    function automatic vec_t mk(logic [3:0] c, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
        vec_t v;
        v.ctl = c; v.a = a; v.b = b; v.rd = rd;
        v.data = ref_data(c, a, b);
        v.regwrite = ~c[3];
        v.illegal = c[3];
        v.lat = ref_lat(c, b);
        return v;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        check32(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one op from IDLE, wait for its result, optionally stall write-back, then return to IDLE
    task automatic do_op(input vec_t v, input int hold);
        int  edges;
        bit  ok_busy;
        check1("idle_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_alu_control = v.ctl; in_op_a = v.a; in_op_b = v.b; in_rd = v.rd;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0; in_alu_control = 4'($urandom_range(0, 15));
        in_op_a = $urandom; in_op_b = $urandom; in_rd = 5'($urandom_range(0, 31));
        edges = 0; ok_busy = 1'b1;
        while (out_valid !== 1'b1 && edges < 200) begin
            if (busy !== 1'b1 || in_ready !== 1'b0) ok_busy = 1'b0;
            tick();
            edges++;
        end
        check1("out_valid_seen", out_valid, 1'b1);
        check32("latency", 32'(edges + 1), 32'(v.lat));
        check1("busy_not_ready_during_op", ok_busy, 1'b1);
        check32("out_data", out_data, v.data);
        check32("out_rd", {27'd0, out_rd}, {27'd0, v.rd});
        check1("out_regwrite", out_regwrite, v.regwrite);
        check1("out_illegal", out_illegal, v.illegal);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1; in_alu_control = 4'b0010;
            tick();
            check1("hold_out_valid", out_valid, 1'b1);
            check32("hold_out_data", out_data, v.data);
            check1("hold_out_illegal", out_illegal, v.illegal);
            check1("hold_out_regwrite", out_regwrite, v.regwrite);
            check1("hold_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        check1("post_out_valid", out_valid, 1'b0);
        check1("post_in_ready", in_ready, 1'b1);
        check1("post_busy", busy, 1'b0);
    endtask

    initial begin
        vec_t vecs[12];
        vec_t v;
        bit   quiet;

        reset = 1'b1; in_valid = 1'b0; in_alu_control = 4'b0000;
        in_op_a = 32'd0; in_op_b = 32'd0; in_rd = 5'd0; out_ready = 1'b1;

        // Hand-computed expectations
        vecs[0]  = '{4'b0010, 32'd5, 32'd7, 5'd3, 32'd12, 1'b1, 1'b0, 2};
        vecs[1]  = '{4'b0100, 32'd0, 32'd1, 5'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, 2};
        vecs[2]  = '{4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd5, 32'h00F0_1200, 1'b1, 1'b0, 2};
        vecs[3]  = '{4'b0001, 32'hA000_0001, 32'h0500_0010, 5'd6, 32'hA500_0011, 1'b1, 1'b0, 2};
        vecs[4]  = '{4'b0011, 32'd3, 32'h0000_0024, 5'd7, 32'h0000_0030, 1'b1, 1'b0, 2};
        vecs[5]  = '{4'b0101, 32'h8000_0000, 32'd31, 5'd8, 32'd1, 1'b1, 1'b0, 2};
        vecs[6]  = '{4'b0111, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd9, 32'hF0F0_0F0F, 1'b1, 1'b0, 2};
        vecs[8]  = '{4'b0110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd1, 1'b1, 1'b0, 33};
        vecs[11] = '{4'b1111, 32'd9, 32'd9, 5'd31, 32'd0, 1'b0, 1'b1, 2};
`ifdef MUL_EARLY_EXIT_EN
        vecs[7]  = '{4'b0110, 32'd7, 32'd5, 5'd10, 32'd35, 1'b1, 1'b0, 4};
        vecs[9]  = '{4'b0110, 32'd123, 32'd0, 5'd12, 32'd0, 1'b1, 1'b0, 2};
        vecs[10] = '{4'b0110, 32'h0001_0000, 32'h0001_0000, 5'd13, 32'd0, 1'b1, 1'b0, 18};
`else
        vecs[7]  = '{4'b0110, 32'd7, 32'd5, 5'd10, 32'd35, 1'b1, 1'b0, 33};
        vecs[9]  = '{4'b0110, 32'd123, 32'd0, 5'd12, 32'd0, 1'b1, 1'b0, 33};
        vecs[10] = '{4'b0110, 32'h0001_0000, 32'h0001_0000, 5'd13, 32'd0, 1'b1, 1'b0, 33};
`endif

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check1("rst_in_ready", in_ready, 1'b1);
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_busy", busy, 1'b0);
        check32("rst_out_data", out_data, 32'd0);
        check32("rst_out_rd", {27'd0, out_rd}, 32'd0);
        check1("rst_out_regwrite", out_regwrite, 1'b0);
        check1("rst_out_illegal", out_illegal, 1'b0);
        check32("idle_alu_ctl", {28'd0, alu_ctl}, 32'd2);
        check32("idle_alu_a", alu_a, 32'd0);

        for (int i = 0; i < 12; i++) do_op(vecs[i], 0);

        // Illegal op stalled by write-back for five cycles while in_valid stays high
        v = '{4'b1010, 32'd77, 32'd88, 5'd17, 32'd0, 1'b0, 1'b1, 2};
        do_op(v, 5);

        // Reset partway through a MUL discards it
        check1("mr_in_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_alu_control = 4'b0110; in_op_a = 32'd9; in_op_b = 32'hFFFF_FFFF; in_rd = 5'd2;
        tick();
        in_valid = 1'b0;
        repeat (9) tick();
        check1("mr_busy_before_reset", busy, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check1("mr_in_ready", in_ready, 1'b1);
        check1("mr_out_valid", out_valid, 1'b0);
        check1("mr_busy", busy, 1'b0);
        check32("mr_out_data", out_data, 32'd0);
        quiet = 1'b1;
        repeat (40) begin
            tick();
            if (out_valid !== 1'b0) quiet = 1'b0;
        end
        check1("mr_no_late_valid", quiet, 1'b1);
        do_op(mk(4'b0010, 32'd1, 32'd1, 5'd1), 0);

        // Random ops against the behavioural model
        for (int n = 0; n < 30; n++) begin
            logic [31:0] rb;
            rb = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 300));
            do_op(mk(4'($urandom_range(0, 15)), $urandom, rb, 5'($urandom_range(0, 31))),
                  int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
